// File: rtl/fp_addsub_ctrl.sv
// Multi-cycle IEEE-754 binary32 adder/subtractor: align, add/sub, serial normalise, optional round.
// Define FP_ADDSUB_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp_addsub_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow
);

`ifdef FP_ADDSUB_ROUND_EN
  typedef enum logic [2:0] {StIdle, StAlign, StAddsub, StNorm, StRound, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StAlign, StAddsub, StNorm, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        op_q, op_d;
  logic [26:0] x_q, x_d, y_q, y_d;   // {sig24, guard, round, sticky}
  logic [27:0] m_q, m_d;             // carry + x/y layout
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [31:0] result_q, result_d;
  logic        overflow_q, overflow_d;

  // Alignment datapath; exponent-0 inputs collapse to zero magnitude.
  logic [30:0] mag_a, mag_b, mag_l, mag_s;
  logic        swap, special;
  logic [7:0]  exp_diff;
  logic [4:0]  shamt;
  logic [23:0] sig_l, sig_s;
  logic [53:0] wide;

  assign mag_a    = (a_q[30:23] == 8'd0) ? 31'd0 : a_q[30:0];
  assign mag_b    = (b_q[30:23] == 8'd0) ? 31'd0 : b_q[30:0];
  assign swap     = mag_b > mag_a;
  assign mag_l    = swap ? mag_b : mag_a;
  assign mag_s    = swap ? mag_a : mag_b;
  assign special  = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
  assign exp_diff = mag_l[30:23] - mag_s[30:23];
  assign shamt    = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
  assign sig_l    = {|mag_l[30:23], mag_l[22:0]};
  assign sig_s    = {|mag_s[30:23], mag_s[22:0]};
  assign wide     = {sig_s, 3'b000, 27'd0} >> shamt;

`ifdef FP_ADDSUB_ROUND_EN
  logic        rnd_inc;
  logic [24:0] rnd_sig;
  assign rnd_inc = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
  assign rnd_sig = {1'b0, m_q[26:3]} + {24'd0, rnd_inc};
`endif

  logic norm_done;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    m_d        = m_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    norm_done  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = StAlign;
        end
      end
      StAlign: begin
        if (special) begin
          result_d   = 32'h7FC0_0000;
          overflow_d = 1'b0;
          state_d    = StDone;
        end else begin
          x_d     = {sig_l, 3'b000};
          y_d     = {wide[53:28], wide[27] | (|wide[26:0])};
          exp_d   = mag_l[30:23];
          sign_d  = swap ? (b_q[31] ^ op_q) : a_q[31];
          sub_d   = op_q ^ a_q[31] ^ b_q[31];
          state_d = StAddsub;
        end
      end
      StAddsub: begin
        m_d     = sub_q ? ({1'b0, x_q} - {1'b0, y_q}) : ({1'b0, x_q} + {1'b0, y_q});
        state_d = StNorm;
      end
      StNorm: begin
        if (m_q[27]) begin
          m_d   = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
          exp_d = exp_q + 8'd1;
          if (exp_q == 8'd254) begin
            result_d   = {sign_q, 8'hFF, 23'd0};
            overflow_d = 1'b1;
            state_d    = StDone;
          end else begin
            norm_done = 1'b1;
          end
        end else if (m_q == 28'd0) begin
          result_d   = 32'd0;
          overflow_d = 1'b0;
          state_d    = StDone;
        end else if (m_q[26]) begin
          norm_done = 1'b1;
        end else if (exp_q <= 8'd1) begin
          // Next shift would need a denormal exponent; flush instead.
          result_d   = {sign_q, 31'd0};
          overflow_d = 1'b0;
          state_d    = StDone;
        end else begin
          m_d   = {m_q[26:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
        if (norm_done) begin
`ifdef FP_ADDSUB_ROUND_EN
          state_d = StRound;
`else
          result_d   = {sign_q, exp_d, m_d[25:3]};
          overflow_d = 1'b0;
          state_d    = StDone;
`endif
        end
      end
`ifdef FP_ADDSUB_ROUND_EN
      StRound: begin
        overflow_d = 1'b0;
        if (rnd_sig[24]) begin
          if (exp_q == 8'd254) begin
            result_d   = {sign_q, 8'hFF, 23'd0};
            overflow_d = 1'b1;
          end else begin
            result_d = {sign_q, exp_q + 8'd1, rnd_sig[23:1]};
          end
        end else begin
          result_d = {sign_q, exp_q, rnd_sig[22:0]};
        end
        state_d = StDone;
      end
`endif
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 1'b0;
      x_q        <= 27'd0;
      y_q        <= 27'd0;
      m_q        <= 28'd0;
      exp_q      <= 8'd0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      result_q   <= 32'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      m_q        <= m_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Directed-vector bench for fp_addsub_ctrl; expectations follow FP_ADDSUB_ROUND_EN when defined.
module tb_fp_addsub_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] a, b;
  logic        busy, done, overflow;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

`ifdef FP_ADDSUB_ROUND_EN
  localparam int RoundLat = 1;
  localparam logic [31:0] Req030Res = 32'h4B80_0001;
`else
  localparam int RoundLat = 0;
  localparam logic [31:0] Req030Res = 32'h4B80_0000;
`endif

  fp_addsub_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check result, overflow, latency and hold behaviour.
  // With poke set, start is pulsed with junk operands while busy and held into the done cycle.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vop, input logic [31:0] exp_res, input logic exp_ovf,
                        input int exp_lat, input bit poke);
    int cyc;
    @(negedge clk);
    a = va; b = vb; op = vop; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, " busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 60) begin
      if (poke) begin
        a = 32'h1234_5678; b = 32'h3F80_0000; op = ~vop; start = cyc[0];
      end
      @(negedge clk);
      cyc++;
    end
    if (poke) start = 1'b1;
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    @(negedge clk);
    start = 1'b0;
    check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, " held"}, result, exp_res);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    @(negedge clk);
    start = 1'b1;  // reset must win over start
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0; start = 1'b0;

    run_op("1+1", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 4 + RoundLat, 1'b0);
    run_op("3-1", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, 4 + RoundLat, 1'b0);
    run_op("1-1", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 4, 1'b0);
    run_op("grs", 32'h4B80_0000, 32'h3FC0_0000, 1'b0, Req030Res, 1'b0, 4 + RoundLat, 1'b0);
    run_op("-1+2", 32'hBF80_0000, 32'h4000_0000, 1'b0, 32'h3F80_0000, 1'b0, 5 + RoundLat, 1'b0);
    run_op("0+-3", 32'h0000_0000, 32'hC040_0000, 1'b0, 32'hC040_0000, 1'b0, 4 + RoundLat, 1'b0);
    run_op("1--1", 32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h4000_0000, 1'b0, 4 + RoundLat, 1'b0);
    run_op("flush", 32'h8080_0001, 32'h8080_0000, 1'b1, 32'h8000_0000, 1'b0, 4, 1'b0);
    run_op("nan", 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 2, 1'b0);
    run_op("lsb", 32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 1'b0, 27 + RoundLat, 1'b1);
    run_op("ovf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 4, 1'b0);

    // Abort in ADDSUB, with start also asserted alongside reset.
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h3F80_0000; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    rst = 1'b0; start = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort quiet", 32'(saw_done), 32'd0);
    run_op("after", 32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000, 1'b0, 4 + RoundLat, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
